// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port req/ack arbiter in front of a single-port data memory
//
// Purpose: serializes core (port A) and debug loader (port B) accesses onto one
// memory port. Each access holds the memory command for MEM_LATENCY cycles,
// then pulses the granted port's ack for one cycle.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   core_req_i/we_i/addr_i/wdata_i  core request (held until core_ack_o)
//   core_ack_o, core_rdata_o    one-cycle completion pulse, registered load data
//   core_stall_o                freezes the core PC while its access is pending
//   dbg_*                       same handshake for the debug/program loader
//   mem_read_o/mem_write_o      memory enables, high only during BUSY
//   mem_addr_o/mem_wdata_o      latched address / write data
//   mem_rdata_i                 combinational read data for mem_addr_o
//
// Optional build macro: ARB_FIXED_PRIO_EN
//   defined   -> core always wins a simultaneous request
//   undefined -> round-robin on simultaneous requests
module data_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_ack_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_ack_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("data_mem_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                state;
  state_t                state_next;
  logic                  gnt_sel;    // 0 = core, 1 = dbg
  logic                  last_gnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CW-1:0]         cnt;
  logic                  any_req;
  logic                  winner;

  // Winner is only meaningful in IDLE with at least one request pending.
`ifdef ARB_FIXED_PRIO_EN
  assign winner = ~core_req_i;
`else
  assign winner = (core_req_i & dbg_req_i) ? ~last_gnt : ~core_req_i;
`endif
  assign any_req = core_req_i | dbg_req_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      gnt_sel      <= 1'b0;
      last_gnt     <= 1'b1;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cnt          <= '0;
      core_rdata_o <= '0;
      dbg_rdata_o  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_sel   <= winner;
            last_gnt  <= winner;
            lat_we    <= winner ? dbg_we_i    : core_we_i;
            lat_addr  <= winner ? dbg_addr_i  : core_addr_i;
            lat_wdata <= winner ? dbg_wdata_i : core_wdata_i;
            cnt       <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!lat_we) begin
            if (gnt_sel) dbg_rdata_o  <= mem_rdata_i;
            else         core_rdata_o <= mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    core_ack_o   = 1'b0;
    dbg_ack_o    = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    // Address/data keep their last latched values outside BUSY.
    mem_addr_o   = lat_addr;
    mem_wdata_o  = lat_wdata;
    case (state)
      IDLE: begin
        if (any_req) state_next = BUSY;
      end
      BUSY: begin
        mem_read_o  = ~lat_we;
        mem_write_o = lat_we;
        if (cnt == '0) state_next = ACK;
      end
      ACK: begin
        core_ack_o = ~gnt_sel;
        dbg_ack_o  = gnt_sel;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    core_stall_o = core_req_i & ~core_ack_o;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed testbench for data_mem_arbiter (latency 1 and 3 instances)
module tb_data_mem_arbiter;

  logic clk;
  int   tests;
  int   fails;

  // Instance A: MEM_LATENCY = 1
  logic        a_reset, a_core_req, a_core_we, a_core_ack, a_core_stall;
  logic [31:0] a_core_addr, a_core_wdata, a_core_rdata;
  logic        a_dbg_req, a_dbg_we, a_dbg_ack;
  logic [31:0] a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
  logic        a_mem_read, a_mem_write;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B: MEM_LATENCY = 3
  logic        b_reset, b_core_req, b_core_we, b_core_ack, b_core_stall;
  logic [31:0] b_core_addr, b_core_wdata, b_core_rdata;
  logic        b_dbg_req, b_dbg_we, b_dbg_ack;
  logic [31:0] b_dbg_addr, b_dbg_wdata, b_dbg_rdata;
  logic        b_mem_read, b_mem_write;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'hDEADBEEF : {addr[15:0], 16'hC0DE};
  endfunction

  assign a_mem_rdata = mem_model(a_mem_addr);
  assign b_mem_rdata = mem_model(b_mem_addr);

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(a_reset),
    .core_req_i(a_core_req), .core_we_i(a_core_we), .core_addr_i(a_core_addr),
    .core_wdata_i(a_core_wdata), .core_ack_o(a_core_ack), .core_rdata_o(a_core_rdata),
    .core_stall_o(a_core_stall),
    .dbg_req_i(a_dbg_req), .dbg_we_i(a_dbg_we), .dbg_addr_i(a_dbg_addr),
    .dbg_wdata_i(a_dbg_wdata), .dbg_ack_o(a_dbg_ack), .dbg_rdata_o(a_dbg_rdata),
    .mem_read_o(a_mem_read), .mem_write_o(a_mem_write), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(b_reset),
    .core_req_i(b_core_req), .core_we_i(b_core_we), .core_addr_i(b_core_addr),
    .core_wdata_i(b_core_wdata), .core_ack_o(b_core_ack), .core_rdata_o(b_core_rdata),
    .core_stall_o(b_core_stall),
    .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we), .dbg_addr_i(b_dbg_addr),
    .dbg_wdata_i(b_dbg_wdata), .dbg_ack_o(b_dbg_ack), .dbg_rdata_o(b_dbg_rdata),
    .mem_read_o(b_mem_read), .mem_write_o(b_mem_write), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    a_core_req = 0; a_core_we = 0; a_core_addr = '0; a_core_wdata = '0;
    a_dbg_req  = 0; a_dbg_we  = 0; a_dbg_addr  = '0; a_dbg_wdata  = '0;
    b_core_req = 0; b_core_we = 0; b_core_addr = '0; b_core_wdata = '0;
    b_dbg_req  = 0; b_dbg_we  = 0; b_dbg_addr  = '0; b_dbg_wdata  = '0;
  endtask

  // Leaves the bench just after a negedge with reset released.
  task automatic apply_reset();
    a_reset = 1; b_reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_reset = 0; b_reset = 0;
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1; b_reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({a_core_ack, a_dbg_ack, a_mem_read, a_mem_write, a_core_stall, a_mem_addr, a_mem_wdata, a_core_rdata, a_dbg_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_a: ack=%b/%b rd=%b wr=%b addr=%h wdata=%h rdata=%h/%h, expected all zero",
               a_core_ack, a_dbg_ack, a_mem_read, a_mem_write, a_mem_addr, a_mem_wdata, a_core_rdata, a_dbg_rdata);
    end
    tests++;
    if ({b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_core_stall, b_mem_addr, b_mem_wdata, b_core_rdata, b_dbg_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_b: ack=%b/%b rd=%b wr=%b addr=%h wdata=%h rdata=%h/%h, expected all zero",
               b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata, b_core_rdata, b_dbg_rdata);
    end
    a_reset = 0; b_reset = 0;
    @(negedge clk); #1;
    tests++;
    if ({a_core_ack, a_dbg_ack, a_mem_read, a_mem_write, a_mem_addr} !== '0) begin
      fails++;
      $display("FAIL reset_release_idle: ack=%b/%b rd=%b wr=%b addr=%h, expected all zero",
               a_core_ack, a_dbg_ack, a_mem_read, a_mem_write, a_mem_addr);
    end
  endtask

  // Instance A: core load from 0x10.
  task automatic test_core_load();
    a_core_req = 1; a_core_we = 0; a_core_addr = 32'h10; #1;
    tests++;
    if (a_core_stall !== 1'b1 || a_mem_read !== 1'b0) begin
      fails++; $display("FAIL load_c0: stall=%b rd=%b, expected stall=1 rd=0", a_core_stall, a_mem_read);
    end
    @(negedge clk); #1;
    tests++;
    if (a_mem_read !== 1'b1 || a_mem_write !== 1'b0 || a_mem_addr !== 32'h10 || a_core_stall !== 1'b1 || a_core_ack !== 1'b0) begin
      fails++; $display("FAIL load_c1: rd=%b wr=%b addr=%h stall=%b ack=%b, expected 1 0 00000010 1 0",
                        a_mem_read, a_mem_write, a_mem_addr, a_core_stall, a_core_ack);
    end
    @(negedge clk); #1;
    tests++;
    if (a_core_ack !== 1'b1 || a_core_rdata !== 32'hDEADBEEF || a_core_stall !== 1'b0 || a_mem_read !== 1'b0 || a_dbg_ack !== 1'b0) begin
      fails++; $display("FAIL load_c2: ack=%b rdata=%h stall=%b rd=%b dbg_ack=%b, expected 1 deadbeef 0 0 0",
                        a_core_ack, a_core_rdata, a_core_stall, a_mem_read, a_dbg_ack);
    end
    a_core_req = 0;
    @(negedge clk); #1;
    tests++;
    if (a_core_ack !== 1'b0 || a_mem_read !== 1'b0 || a_core_rdata !== 32'hDEADBEEF || a_mem_addr !== 32'h10) begin
      fails++; $display("FAIL load_c3: ack=%b rd=%b rdata=%h addr=%h, expected 0 0 deadbeef 00000010",
                        a_core_ack, a_mem_read, a_core_rdata, a_mem_addr);
    end
  endtask

  // Instance A: core store must not disturb core_rdata.
  task automatic test_core_store();
    a_core_req = 1; a_core_we = 1; a_core_addr = 32'h40; a_core_wdata = 32'h0000_55AA;
    @(negedge clk); #1;
    tests++;
    if (a_mem_write !== 1'b1 || a_mem_read !== 1'b0 || a_mem_addr !== 32'h40 || a_mem_wdata !== 32'h55AA) begin
      fails++; $display("FAIL store_c1: wr=%b rd=%b addr=%h wdata=%h, expected 1 0 00000040 000055aa",
                        a_mem_write, a_mem_read, a_mem_addr, a_mem_wdata);
    end
    @(negedge clk); #1;
    tests++;
    if (a_core_ack !== 1'b1 || a_core_rdata !== 32'hDEADBEEF || a_mem_write !== 1'b0) begin
      fails++; $display("FAIL store_c2: ack=%b rdata=%h wr=%b, expected 1 deadbeef 0",
                        a_core_ack, a_core_rdata, a_mem_write);
    end
    a_core_req = 0; a_core_we = 0;
    @(negedge clk); #1;
  endtask

  // Instance B: dbg store with MEM_LATENCY = 3.
  task automatic test_dbg_store();
    b_dbg_req = 1; b_dbg_we = 1; b_dbg_addr = 32'h20; b_dbg_wdata = 32'h12345678;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      tests++;
      if (b_mem_write !== 1'b1 || b_mem_read !== 1'b0 || b_mem_addr !== 32'h20 || b_mem_wdata !== 32'h12345678 ||
          b_dbg_ack !== 1'b0 || b_core_ack !== 1'b0) begin
        fails++; $display("FAIL dbg_store_c%0d: wr=%b rd=%b addr=%h wdata=%h acks=%b/%b, expected 1 0 00000020 12345678 0/0",
                          c, b_mem_write, b_mem_read, b_mem_addr, b_mem_wdata, b_core_ack, b_dbg_ack);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (b_dbg_ack !== 1'b1 || b_core_ack !== 1'b0 || b_dbg_rdata !== 32'h0 || b_mem_write !== 1'b0) begin
      fails++; $display("FAIL dbg_store_c4: dbg_ack=%b core_ack=%b dbg_rdata=%h wr=%b, expected 1 0 00000000 0",
                        b_dbg_ack, b_core_ack, b_dbg_rdata, b_mem_write);
    end
    b_dbg_req = 0; b_dbg_we = 0;
    @(negedge clk); #1;
    tests++;
    if (b_dbg_ack !== 1'b0 || b_core_ack !== 1'b0 || b_mem_write !== 1'b0) begin
      fails++; $display("FAIL dbg_store_c5: acks=%b/%b wr=%b, expected 0/0 0", b_core_ack, b_dbg_ack, b_mem_write);
    end
  endtask

  // Instance A: both ports request every cycle from reset.
  task automatic test_back_to_back();
    logic exp_core;
    logic exp_dbg;
    apply_reset();
    a_core_req = 1; a_core_we = 0; a_core_addr = 32'h10;
    a_dbg_req  = 1; a_dbg_we  = 0; a_dbg_addr  = 32'h30;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
`ifdef ARB_FIXED_PRIO_EN
      exp_core = (c == 2) || (c == 5) || (c == 8) || (c == 11);
      exp_dbg  = 1'b0;
`else
      exp_core = (c == 2) || (c == 8);
      exp_dbg  = (c == 5) || (c == 11);
`endif
      tests++;
      if (a_core_ack !== exp_core || a_dbg_ack !== exp_dbg) begin
        fails++; $display("FAIL rr_c%0d: core_ack=%b dbg_ack=%b, expected %b %b", c, a_core_ack, a_dbg_ack, exp_core, exp_dbg);
      end
      if (exp_dbg) begin
        tests++;
        if (a_dbg_rdata !== 32'h0030C0DE) begin
          fails++; $display("FAIL rr_dbg_rdata_c%0d: got %h, expected 0030c0de", c, a_dbg_rdata);
        end
      end
    end
    a_core_req = 0; a_dbg_req = 0;
    @(negedge clk); #1;
  endtask

  // Instance B: core address moves during BUSY; the latched address must stay.
  task automatic test_addr_hold();
    b_core_req = 1; b_core_we = 0; b_core_addr = 32'h10;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      tests++;
      if (b_mem_addr !== 32'h10 || b_mem_read !== 1'b1 || b_core_stall !== 1'b1) begin
        fails++; $display("FAIL addr_hold_c%0d: addr=%h rd=%b stall=%b, expected 00000010 1 1",
                          c, b_mem_addr, b_mem_read, b_core_stall);
      end
      b_core_addr = 32'h44;
    end
    @(negedge clk); #1;
    tests++;
    if (b_core_ack !== 1'b1 || b_core_rdata !== 32'hDEADBEEF || b_core_stall !== 1'b0 || b_mem_addr !== 32'h10) begin
      fails++; $display("FAIL addr_hold_ack: ack=%b rdata=%h stall=%b addr=%h, expected 1 deadbeef 0 00000010",
                        b_core_ack, b_core_rdata, b_core_stall, b_mem_addr);
    end
    b_core_req = 0;
    @(negedge clk); #1;
  endtask

  // Instance B: reset asserted in the 2nd BUSY cycle of a store.
  task automatic test_reset_mid_busy();
    b_core_req = 1; b_core_we = 1; b_core_addr = 32'h50; b_core_wdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    tests++;
    if (b_mem_write !== 1'b1 || b_mem_addr !== 32'h50) begin
      fails++; $display("FAIL rst_busy_c1: wr=%b addr=%h, expected 1 00000050", b_mem_write, b_mem_addr);
    end
    @(negedge clk); #1;
    tests++;
    if (b_mem_write !== 1'b1 || b_mem_wdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL rst_busy_c2: wr=%b wdata=%h, expected 1 cafef00d", b_mem_write, b_mem_wdata);
    end
    b_reset = 1; b_core_req = 0; b_core_we = 0;
    @(negedge clk); #1;
    tests++;
    if ({b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata, b_core_rdata} !== '0) begin
      fails++; $display("FAIL rst_busy_c3: acks=%b/%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, expected all zero",
                        b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata, b_core_rdata);
    end
    b_reset = 0;
    for (int c = 4; c < 8; c++) begin
      @(negedge clk); #1;
      tests++;
      if ({b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata, b_core_rdata, b_dbg_rdata} !== '0) begin
        fails++; $display("FAIL rst_after_c%0d: acks=%b/%b rd=%b wr=%b addr=%h wdata=%h, expected all zero",
                          c, b_core_ack, b_dbg_ack, b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    a_reset = 1;
    b_reset = 1;
    idle_inputs();
    test_reset();
    test_core_load();
    test_core_store();
    test_dbg_store();
    test_back_to_back();
    test_addr_hold();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port A, "core") and a program/debug loader (port B, "dbg").
- Each port uses a req/ack handshake. A 3-state FSM serializes the accesses.
- The block stretches each memory command for a configurable number of cycles and returns read data per port.
- It generates a stall to freeze the core PC while a core access is pending.

Parameters:
- DATA_WIDTH, 32, memory data width.
- ADDR_WIDTH, 32, byte address width.
- MEM_LATENCY, 1, cycles a command is held on the memory side; must be >= 1. A value of 0 is illegal and fails elaboration.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- core_req_i  in  1  core access request; held until core_ack_o
- core_we_i  in  1  1 = store, 0 = load
- core_addr_i  in  ADDR_WIDTH  core address
- core_wdata_i  in  DATA_WIDTH  core store data
- core_ack_o  out  1  one-cycle completion pulse
- core_rdata_o  out  DATA_WIDTH  registered load data, valid from the ack cycle
- core_stall_o  out  1  core_req_i & ~core_ack_o (combinational)
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ack_o, dbg_rdata_o  same as the core set, for port B
- mem_read_o  out  1  memory read enable
- mem_write_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, combinational from mem_addr_o

Behaviour:
- States: IDLE, BUSY, ACK. Registers:
  - gnt_sel: 0 = core, 1 = dbg
  - last_gnt
  - lat_we, lat_addr, lat_wdata
  - cnt, width clog2(MEM_LATENCY+1)
- Reset values:
  - state = IDLE, last_gnt = 1 (dbg), so core wins the first conflict.
  - cnt = 0, latched registers = 0.
  - Outputs: all acks 0, rdata 0, mem_read/mem_write 0, mem_addr/mem_wdata 0.
- IDLE, arbitration at the rising edge:
  - If no request: stay in IDLE.
  - If exactly one request: grant that port.
  - If both request: grant the port != last_gnt (round-robin).
  - On grant:
    - Latch we/addr/wdata of the granted port.
    - gnt_sel <= winner, last_gnt <= winner.
    - cnt <= MEM_LATENCY-1; go to BUSY.
- BUSY:
  - mem_addr_o = lat_addr, mem_wdata_o = lat_wdata.
  - mem_read_o = ~lat_we, mem_write_o = lat_we, held for all MEM_LATENCY cycles. A repeated write of the same data is idempotent.
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0 at the edge:
    - For a load, capture mem_rdata_i into the granted port's rdata register.
    - Go to ACK.
  - A store leaves that port's rdata unchanged.
- ACK:
  - The granted port's ack_o = 1 for exactly this cycle.
  - Memory enables are 0. No arbitration happens; go to IDLE.
  - The requester must drop req in the ack cycle. A req still high in the following IDLE cycle is a new request.
- Latency: req seen at edge n, BUSY for cycles n+1..n+MEM_LATENCY, ack in cycle n+MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+2 cycles.
- Changes on any requester input while in BUSY or ACK are ignored; latched values are used.
- A losing requester keeps req high and is granted at the next IDLE. Round-robin bounds its wait to one access.
- In IDLE and ACK, mem_addr_o/mem_wdata_o hold their last latched values; only the enables are forced to 0.
- Reset mid-BUSY: the next edge forces IDLE and the reset values. No ack is issued. A write may already have committed for that address.
- core_stall_o is high from core req assertion through BUSY and low in the ack cycle, so the PC advances exactly once.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: on a simultaneous request the core always wins and last_gnt is ignored. The dbg port can starve while the core requests every IDLE cycle.
- Undefined: round-robin arbitration as described above.
- Ports and timing are identical in both builds.

Test Plan:
- Single core load, MEM_LATENCY=1, mem returns 0xDEADBEEF for addr 0x10. Core req at edge 0 -> mem_read_o=1 in cycle 1 only -> core_ack_o=1 in cycle 2 -> core_rdata_o=0xDEADBEEF. core_stall_o=1 in cycles 0-1 and 0 in cycle 2.
- Dbg store of 0x12345678 to 0x20, MEM_LATENCY=3 -> mem_write_o=1 for cycles 1-3 with addr 0x20 -> dbg_ack_o in cycle 4. dbg_rdata_o unchanged, core_ack_o never asserts.
- Both ports request continuously from reset -> grant order core, dbg, core, dbg. Acks alternate with spacing of MEM_LATENCY+2 cycles. With ARB_FIXED_PRIO_EN, only the core is acked.
- Core addr changed from 0x10 to 0x44 during BUSY -> mem_addr_o stays 0x10 for the whole access.
- reset asserted in the 2nd BUSY cycle of a MEM_LATENCY=3 store -> next cycle: state IDLE, all enables 0, no ack. After reset is released with no requests, outputs remain at their reset values.
